hot_page_filter: RTL

//   Consumes the (valid, addr, min_cnt) stream from the count-min sketch minimum stage.

---
 rtl/hot_page_filter.sv | 96 +++++++++
 1 files changed

// File: rtl/hot_page_filter.sv
// hot_page_filter: threshold hot-address filter with repeat suppression and show-ahead output FIFO
module hot_page_filter #(
   parameter int ADDR_SIZE     = 22,
   parameter int CNT_SIZE      = 32,
   parameter int FIFO_DEPTH    = 16,
   parameter int DEDUP_ENTRIES = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          query_rst_n,
   input  logic                          in_valid,
   input  logic [ADDR_SIZE-1:0]          in_addr,
   input  logic [CNT_SIZE-1:0]           in_cnt,
   input  logic [CNT_SIZE-1:0]           threshold,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ADDR_SIZE-1:0]          out_addr,
   output logic [CNT_SIZE-1:0]           out_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [31:0]                   hot_total,
   output logic [31:0]                   drop_total
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int DW = DEDUP_ENTRIES > 1 ? $clog2(DEDUP_ENTRIES) : 1;
   logic                          s1_hit;
   logic [ADDR_SIZE-1:0]          s1_addr;
   logic [CNT_SIZE-1:0]           s1_cnt;
   logic [ADDR_SIZE+CNT_SIZE-1:0] mem [FIFO_DEPTH];
   logic [ADDR_SIZE-1:0]          ded_a [DEDUP_ENTRIES];
   logic [DEDUP_ENTRIES-1:0]      ded_v;
   logic [PW-1:0]                 wr_ptr, rd_ptr;
   logic [DW-1:0]                 rr_ptr;
   logic [LW-1:0]                 level;
   logic                          dup, push_req, full, pop, push, drop;
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < DEDUP_ENTRIES; i++)
         dup = dup | (ded_v[i] && ded_a[i] == s1_addr);
      dup = dup && s1_hit;
   end
   assign push_req   = s1_hit && !dup;
   assign full       = level == LW'(FIFO_DEPTH);
   assign out_valid  = query_rst_n && level != '0;
   assign pop        = out_valid && out_ready;
   assign push       = push_req && (!full || pop);
   assign drop       = push_req && full && !pop;
   assign fifo_level = level;
   // Head is zeroed when empty so nothing stale or uninitialised leaks out.
   assign {out_addr, out_cnt} = out_valid ? mem[rd_ptr] : '0;
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr]   <= {s1_addr, s1_cnt};
         ded_a[rr_ptr] <= s1_addr;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hit     <= 1'b0;
         s1_addr    <= '0;
         s1_cnt     <= '0;
         ded_v      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rr_ptr     <= '0;
         level      <= '0;
         hot_total  <= '0;
         drop_total <= '0;
      end else if (!query_rst_n) begin
         s1_hit     <= 1'b0;
         s1_addr    <= '0;
         s1_cnt     <= '0;
         ded_v      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rr_ptr     <= '0;
         level      <= '0;
         hot_total  <= '0;
         drop_total <= '0;
      end else begin
         s1_hit  <= in_valid && threshold != '0 && in_cnt >= threshold;
         s1_addr <= in_addr;
         s1_cnt  <= in_cnt;
         if (push) begin
            wr_ptr        <= wr_ptr + PW'(1);
            ded_v[rr_ptr] <= 1'b1;
            rr_ptr        <= rr_ptr == DW'(DEDUP_ENTRIES - 1) ? '0 : rr_ptr + DW'(1);
            if (hot_total != '1) hot_total <= hot_total + 32'd1;
         end
         if (drop && drop_total != '1) drop_total <= drop_total + 32'd1;
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop) level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
      end
   end
endmodule
